// File: rtl/controlador_copia_hd_pkg.sv
// Shared state encoding and default widths for the HD-to-data-memory copy controller.
package controlador_copia_hd_pkg;

    typedef enum logic [1:0] {
        OCIOSO      = 2'd0,
        LE_HD       = 2'd1,
        ESCREVE_MEM = 2'd2,
        FIM         = 2'd3
    } estado_t;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MEM_ADDR_W = 10;
    localparam int DEF_HD_ADDR_W  = 12;
    localparam int DEF_LEN_W      = 10;

endpackage

// File: rtl/controlador_copia_hd_contador.sv
// Loadable HD/memory pointer pair plus copied-word counter for the copy controller.
module contador_enderecos_copia #(
    parameter int MEM_ADDR_W = 10,
    parameter int HD_ADDR_W  = 12,
    parameter int LEN_W      = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  inc,
    input  logic [HD_ADDR_W-1:0]  hd_base,
    input  logic [MEM_ADDR_W-1:0] mem_base,
    input  logic [LEN_W-1:0]      len,
    output logic [HD_ADDR_W-1:0]  hd_ptr,
    output logic [MEM_ADDR_W-1:0] mem_ptr,
    output logic [LEN_W-1:0]      count,
    output logic                  last
);

    logic [LEN_W-1:0] len_r;

    // Pointers wrap naturally at their register width.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hd_ptr  <= '0;
            mem_ptr <= '0;
            count   <= '0;
            len_r   <= '0;
        end else if (load) begin
            hd_ptr  <= hd_base;
            mem_ptr <= mem_base;
            count   <= '0;
            len_r   <= len;
        end else if (inc) begin
            hd_ptr  <= hd_ptr + HD_ADDR_W'(1);
            mem_ptr <= mem_ptr + MEM_ADDR_W'(1);
            count   <= count + LEN_W'(1);
        end
    end

    assign last = ((count + LEN_W'(1)) == len_r);

endmodule

// File: rtl/controlador_copia_hd.sv
// Arbitrates the data memory port between the processor and an HD-to-memory block copy.
module controlador_copia_hd
    import controlador_copia_hd_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_ADDR_W = DEF_MEM_ADDR_W,
    parameter int HD_ADDR_W  = DEF_HD_ADDR_W,
    parameter int LEN_W      = DEF_LEN_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [HD_ADDR_W-1:0]  hd_base,
    input  logic [MEM_ADDR_W-1:0] mem_base,
    input  logic [LEN_W-1:0]      len,
    input  logic [MEM_ADDR_W-1:0] proc_mem_addr,
    input  logic [DATA_W-1:0]     proc_mem_wdata,
    input  logic                  proc_MemWrite,
    input  logic [DATA_W-1:0]     HD_out,
    output logic [HD_ADDR_W-1:0]  hd_addr,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_we,
    output logic                  proc_stall,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_W-1:0]      words_copied
);

    estado_t                 estado, proximo;
    logic                    load, inc, last;
    logic [MEM_ADDR_W-1:0]   mem_ptr;

    contador_enderecos_copia #(
        .MEM_ADDR_W (MEM_ADDR_W),
        .HD_ADDR_W  (HD_ADDR_W),
        .LEN_W      (LEN_W)
    ) u_contador (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .inc      (inc),
        .hd_base  (hd_base),
        .mem_base (mem_base),
        .len      (len),
        .hd_ptr   (hd_addr),
        .mem_ptr  (mem_ptr),
        .count    (words_copied),
        .last     (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) estado <= OCIOSO;
        else       estado <= proximo;
    end

    always_comb begin
        proximo   = estado;
        load      = 1'b0;
        inc       = 1'b0;
        mem_addr  = proc_mem_addr;
        mem_wdata = proc_mem_wdata;
        mem_we    = proc_MemWrite;
        busy      = 1'b1;
        done      = 1'b0;
        case (estado)
            OCIOSO: begin
                busy = 1'b0;
                if (start) begin
                    load    = 1'b1;
                    proximo = (len != '0) ? LE_HD : FIM;
                end
            end
            LE_HD: begin
                mem_addr  = mem_ptr;
                mem_wdata = HD_out;
                mem_we    = 1'b0;
                proximo   = ESCREVE_MEM;
            end
            ESCREVE_MEM: begin
                mem_addr  = mem_ptr;
                mem_wdata = HD_out;
                mem_we    = 1'b1;
                inc       = 1'b1;
                proximo   = last ? FIM : LE_HD;
            end
            FIM: begin
                mem_addr  = mem_ptr;
                mem_wdata = HD_out;
                mem_we    = 1'b0;
                done      = 1'b1;
                proximo   = OCIOSO;
            end
            default: proximo = OCIOSO;
        endcase
    end

    assign proc_stall = busy;

endmodule

// File: tb/tb_controlador_copia_hd.sv
// Scoreboard bench: the driver queues expected memory writes and done pulses, a negedge monitor checks them.
module tb_controlador_copia_hd;

    logic        clk = 1'b0;
    logic        reset, start, proc_MemWrite;
    logic [11:0] hd_base;
    logic [9:0]  mem_base, len, proc_mem_addr;
    logic [31:0] proc_mem_wdata, HD_out;
    logic [11:0] hd_addr;
    logic [9:0]  mem_addr, words_copied;
    logic [31:0] mem_wdata;
    logic        mem_we, proc_stall, busy, done;

    controlador_copia_hd #(
        .DATA_W     (32),
        .MEM_ADDR_W (10),
        .HD_ADDR_W  (12),
        .LEN_W      (10)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .hd_base        (hd_base),
        .mem_base       (mem_base),
        .len            (len),
        .proc_mem_addr  (proc_mem_addr),
        .proc_mem_wdata (proc_mem_wdata),
        .proc_MemWrite  (proc_MemWrite),
        .HD_out         (HD_out),
        .hd_addr        (hd_addr),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_we         (mem_we),
        .proc_stall     (proc_stall),
        .busy           (busy),
        .done           (done),
        .words_copied   (words_copied)
    );

    always #5 clk = ~clk;

    logic [31:0] hd_mem [4096];
    always @(posedge clk) HD_out <= hd_mem[hd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_done;
        int          cycle;
        logic [9:0]  addr;
        logic [31:0] data;
        int          wc;
    } ev_t;
    ev_t q[$];

    int total = 0;
    int bad = 0;
    int win_lo = -1;
    int win_hi = -2;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_wr(input int c, input logic [9:0] a, input logic [31:0] d);
        ev_t e;
        e.is_done = 1'b0; e.cycle = c; e.addr = a; e.data = d; e.wc = 0;
        q.push_back(e);
    endtask

    task automatic push_done(input int c, input int n);
        ev_t e;
        e.is_done = 1'b1; e.cycle = c; e.addr = '0; e.data = '0; e.wc = n;
        q.push_back(e);
    endtask

    // Monitor: stall/busy window plus ordered write/done events
    always @(negedge clk) begin
        ev_t e;
        bit in_win;
        in_win = (cyc >= win_lo) && (cyc <= win_hi);
        check("busy", busy, in_win);
        check("proc_stall", proc_stall, in_win);
        while (q.size() > 0 && q[0].cycle < cyc) begin
            e = q.pop_front();
            total++; bad++;
            $display("FAIL missing_event: event did not occur, expected done=%0d at cycle %0d", e.is_done, e.cycle);
        end
        if (mem_we || done) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_event: we=%0d done=%0d addr=%0h, expected none (cycle %0d)", mem_we, done, mem_addr, cyc);
            end else begin
                e = q.pop_front();
                check("event_cycle", cyc, e.cycle);
                check("event_kind_done", done, e.is_done);
                check("event_kind_we", mem_we, !e.is_done);
                if (e.is_done) check("done_words_copied", words_copied, e.wc);
                else begin
                    check("wr_addr", mem_addr, e.addr);
                    check("wr_data", mem_wdata, e.data);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // rst_at: spec cycle (1 = first cycle after start edge) in which reset is asserted; <0 means none
    task automatic do_copy(input logic [11:0] hb, input logic [9:0] mb, input int n,
                           input bit intf, input bit pw, input int rst_at);
        int s, lim, pend;
        hd_base = hb; mem_base = mb; len = 10'(n); start = 1'b1; proc_MemWrite = pw;
        if (pw) begin
            proc_mem_addr = 10'($urandom); proc_mem_wdata = $urandom;
            push_wr(cyc, proc_mem_addr, proc_mem_wdata);
        end
        next_cycle();
        s = cyc;
        start = 1'b0; proc_MemWrite = 1'b0;
        lim = (rst_at >= 0) ? s + rst_at - 1 : s + 2 * n + 1;
        for (int k = 0; k < n; k++)
            if (s + 1 + 2 * k < lim)
                push_wr(s + 1 + 2 * k, 10'(mb + 10'(k)), hd_mem[12'(hb + 12'(k))]);
        if (rst_at < 0) push_done(s + 2 * n, n);
        win_lo = s;
        win_hi = lim - 1;
        pend = lim - s;
        for (int p = 0; p < pend; p++) begin
            if (intf) begin
                start = 1'($urandom_range(0, 1));
                proc_MemWrite = 1'b1;
                proc_mem_addr = 10'($urandom); proc_mem_wdata = $urandom;
                hd_base = 12'($urandom); mem_base = 10'($urandom); len = 10'($urandom);
            end
            next_cycle();
        end
        start = 1'b0; proc_MemWrite = 1'b0;
        if (rst_at >= 0) begin
            proc_MemWrite = 1'b1; proc_mem_addr = 10'h007; proc_mem_wdata = 32'h1234_5678;
            push_wr(cyc, 10'h007, 32'h1234_5678);
            reset = 1'b1;
            #1;
            check("rst_busy", busy, 0);
            check("rst_stall", proc_stall, 0);
            check("rst_done", done, 0);
            check("rst_words_copied", words_copied, 0);
            check("rst_passthru_addr", mem_addr, 10'h007);
            check("rst_passthru_we", mem_we, 1);
            next_cycle();
            reset = 1'b0; proc_MemWrite = 1'b0;
            next_cycle();
        end else begin
            check("final_words_copied", words_copied, n);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; proc_MemWrite = 1'b0;
        hd_base = '0; mem_base = '0; len = '0; proc_mem_addr = '0; proc_mem_wdata = '0;
        for (int i = 0; i < 4096; i++) hd_mem[i] = $urandom;
        next_cycle();
        next_cycle();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_words_copied", words_copied, 0);
        check("reset_hd_addr", hd_addr, 0);
        reset = 1'b0;
        next_cycle();

        proc_mem_addr = 10'd5; proc_mem_wdata = 32'hDEAD_BEEF; proc_MemWrite = 1'b1;
        push_wr(cyc, 10'd5, 32'hDEAD_BEEF);
        #1;
        check("idle_passthru_addr", mem_addr, 5);
        check("idle_passthru_data", mem_wdata, 32'hDEAD_BEEF);
        next_cycle();
        proc_MemWrite = 1'b0;
        next_cycle();

        hd_mem[16] = 32'hA; hd_mem[17] = 32'hB; hd_mem[18] = 32'hC;
        do_copy(12'h010, 10'h020, 3, 1'b0, 1'b0, -1);
        do_copy(12'h123, 10'h045, 0, 1'b0, 1'b0, -1);
        do_copy(12'hFFF, 10'h3FF, 2, 1'b0, 1'b0, -1);
        do_copy(12'($urandom), 10'($urandom), 5, 1'b1, 1'b1, -1);
        do_copy(12'h200, 10'h100, 4, 1'b0, 1'b0, 3);
        for (int t = 0; t < 10; t++) begin
            do_copy(12'($urandom), 10'($urandom), int'($urandom_range(0, 6)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
            next_cycle();
        end

        repeat (4) next_cycle();
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, expected finish");
        $fatal(1);
    end

endmodule
